// File: rtl/branch_predictor_pkg.sv
// Shared branch predictor types: counter encodings and the table entry layout.
// Entries are sized for the widest supported PC; narrower instances zero-extend.
package branch_predictor_pkg;

    localparam int BP_MAX_DWIDTH = 32;
    localparam int BP_MAX_TAGW   = BP_MAX_DWIDTH - 3;   // smallest table (2 entries) has the widest tag

    localparam logic [1:0] BP_STRONG_NT = 2'b00;
    localparam logic [1:0] BP_WEAK_NT   = 2'b01;
    localparam logic [1:0] BP_WEAK_T    = 2'b10;
    localparam logic [1:0] BP_STRONG_T  = 2'b11;

    typedef struct packed {
        logic                     valid;
        logic [BP_MAX_TAGW-1:0]   tag;
        logic [BP_MAX_DWIDTH-1:0] target;
        logic [1:0]               ctr;
    } bp_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state for a 2-bit saturating taken/not-taken counter.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != BP_STRONG_T) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != BP_STRONG_NT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped fetch predictor: same-cycle lookup, trained by execute-stage
// resolves, with a registered one-cycle mispredict/redirect back to fetch.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int DWIDTH  = 32,
    parameter int ENTRIES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DWIDTH-1:0] fetch_pc_i,
    output logic              pred_taken_o,
    output logic [DWIDTH-1:0] pred_target_o,
    input  logic              resolve_valid_i,
    input  logic [DWIDTH-1:0] resolve_pc_i,
    input  logic              resolve_taken_i,
    input  logic [DWIDTH-1:0] resolve_target_i,
    input  logic              resolve_pred_taken_i,
    input  logic [DWIDTH-1:0] resolve_pred_target_i,
    output logic              mispredict_o,
    output logic [DWIDTH-1:0] redirect_pc_o,
    output logic [31:0]       branch_count_o,
    output logic [31:0]       mispredict_count_o
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = DWIDTH - IDXW - 2;

    bp_entry_t tbl [ENTRIES];

    logic [IDXW-1:0] f_idx, r_idx;
    logic [TAGW-1:0] f_tag, r_tag;
    bp_entry_t       f_ent, r_ent;
    logic            f_hit, r_hit, mispredict;
    logic [1:0]      ctr_next;

    // Byte-offset bits never select an entry.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{fetch_pc_i[1:0], resolve_pc_i[1:0]};

    assign f_idx = fetch_pc_i[IDXW+1:2];
    assign f_tag = fetch_pc_i[DWIDTH-1:IDXW+2];
    assign r_idx = resolve_pc_i[IDXW+1:2];
    assign r_tag = resolve_pc_i[DWIDTH-1:IDXW+2];

    assign f_ent = tbl[f_idx];
    assign r_ent = tbl[r_idx];
    assign f_hit = f_ent.valid && (f_ent.tag == BP_MAX_TAGW'(f_tag));
    assign r_hit = r_ent.valid && (r_ent.tag == BP_MAX_TAGW'(r_tag));

    assign pred_taken_o  = f_hit && f_ent.ctr[1];
    assign pred_target_o = pred_taken_o ? f_ent.target[DWIDTH-1:0]
                                        : fetch_pc_i + DWIDTH'(4);

    // Predicted target only matters when the branch actually went taken.
    assign mispredict = (resolve_taken_i != resolve_pred_taken_i) ||
                        (resolve_taken_i && (resolve_target_i != resolve_pred_target_i));

    sat_counter2 u_ctr (
        .ctr      (r_ent.ctr),
        .taken    (resolve_taken_i),
        .ctr_next (ctr_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl[i].valid  <= 1'b0;
                tbl[i].tag    <= '0;
                tbl[i].target <= '0;
                tbl[i].ctr    <= BP_WEAK_NT;
            end
            mispredict_o       <= 1'b0;
            redirect_pc_o      <= '0;
            branch_count_o     <= '0;
            mispredict_count_o <= '0;
        end else begin
            mispredict_o <= 1'b0;
            if (resolve_valid_i) begin
                branch_count_o <= branch_count_o + 32'd1;
                if (mispredict) begin
                    mispredict_o       <= 1'b1;
                    redirect_pc_o      <= resolve_taken_i ? resolve_target_i
                                                          : resolve_pc_i + DWIDTH'(4);
                    mispredict_count_o <= mispredict_count_o + 32'd1;
                end
                if (r_hit) begin
                    tbl[r_idx].ctr <= ctr_next;
                    if (resolve_taken_i) tbl[r_idx].target <= BP_MAX_DWIDTH'(resolve_target_i);
                end else if (resolve_taken_i) begin
                    tbl[r_idx].valid  <= 1'b1;
                    tbl[r_idx].tag    <= BP_MAX_TAGW'(r_tag);
                    tbl[r_idx].target <= BP_MAX_DWIDTH'(resolve_target_i);
                    tbl[r_idx].ctr    <= BP_WEAK_T;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (DWIDTH=32, ENTRIES=16): directed
// scenarios plus randomized traffic against a behavioural predictor model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fetch_pc_i = '0;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        resolve_valid_i = 1'b0;
    logic [31:0] resolve_pc_i = '0;
    logic        resolve_taken_i = 1'b0;
    logic [31:0] resolve_target_i = '0;
    logic        resolve_pred_taken_i = 1'b0;
    logic [31:0] resolve_pred_target_i = '0;
    logic        mispredict_o;
    logic [31:0] redirect_pc_o;
    logic [31:0] branch_count_o;
    logic [31:0] mispredict_count_o;

    int n_chk = 0;
    int n_fail = 0;

    branch_predictor #(.DWIDTH(32), .ENTRIES(16)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .fetch_pc_i            (fetch_pc_i),
        .pred_taken_o          (pred_taken_o),
        .pred_target_o         (pred_target_o),
        .resolve_valid_i       (resolve_valid_i),
        .resolve_pc_i          (resolve_pc_i),
        .resolve_taken_i       (resolve_taken_i),
        .resolve_target_i      (resolve_target_i),
        .resolve_pred_taken_i  (resolve_pred_taken_i),
        .resolve_pred_target_i (resolve_pred_target_i),
        .mispredict_o          (mispredict_o),
        .redirect_pc_o         (redirect_pc_o),
        .branch_count_o        (branch_count_o),
        .mispredict_count_o    (mispredict_count_o)
    );

    always #5 clk = ~clk;

    // Reference model: per-slot valid/tag/target and counter strength 0..3.
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    bit          m_mp;
    logic [31:0] m_redir;
    logic [31:0] m_bcnt, m_mcnt;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
        end
        m_mp = 0; m_redir = '0; m_bcnt = '0; m_mcnt = '0;
    endfunction

    function automatic void model_predict(input logic [31:0] pc, output bit t, output logic [31:0] tgt);
        int i = int'((pc >> 2) % 16);
        t   = m_valid[i] && (m_tag[i] == (pc >> 6)) && (m_ctr[i] >= 2);
        tgt = t ? m_tgt[i] : pc + 32'd4;
    endfunction

    function automatic void model_resolve(input logic [31:0] pc, input bit t, input logic [31:0] tgt,
                                          input bit pt, input logic [31:0] ptg);
        int i = int'((pc >> 2) % 16);
        bit hit = m_valid[i] && (m_tag[i] == (pc >> 6));
        bit mp = (t != pt) || (t && tgt != ptg);
        m_mp = mp;
        m_bcnt++;
        if (mp) begin
            m_mcnt++;
            m_redir = t ? tgt : pc + 32'd4;
        end
        if (hit) begin
            m_ctr[i] = t ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1) : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
            if (t) m_tgt[i] = tgt;
        end else if (t) begin
            m_valid[i] = 1; m_tag[i] = pc >> 6; m_tgt[i] = tgt; m_ctr[i] = 2;
        end
    endfunction

    // Drive-only helpers; each scenario task does its own comparisons.
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic do_resolve(input logic [31:0] pc, input bit t, input logic [31:0] tgt,
                              input bit pt, input logic [31:0] ptg);
        resolve_valid_i = 1'b1; resolve_pc_i = pc; resolve_taken_i = t;
        resolve_target_i = tgt; resolve_pred_taken_i = pt; resolve_pred_target_i = ptg;
        @(posedge clk);
        model_resolve(pc, t, tgt, pt, ptg);
        #1;
        resolve_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        fetch_pc_i = 32'h100; #1;
        n_chk++; if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL reset_taken got %0b want 0", pred_taken_o); end
        n_chk++; if (pred_target_o !== 32'h104) begin n_fail++; $display("FAIL reset_target got %h want 00000104", pred_target_o); end
        n_chk++; if (branch_count_o !== 0 || mispredict_count_o !== 0) begin n_fail++; $display("FAIL reset_counts got %0d/%0d want 0/0", branch_count_o, mispredict_count_o); end
        n_chk++; if (mispredict_o !== 1'b0 || redirect_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_redirect got %0b/%h want 0/0", mispredict_o, redirect_pc_o); end
    endtask

    task automatic test_cold_taken();
        do_reset();
        do_resolve(32'h100, 1, 32'h80, 0, 32'h104);
        n_chk++; if (mispredict_o !== 1'b1 || redirect_pc_o !== 32'h80) begin n_fail++; $display("FAIL cold_redirect got %0b/%h want 1/00000080", mispredict_o, redirect_pc_o); end
        n_chk++; if (branch_count_o !== 1 || mispredict_count_o !== 1) begin n_fail++; $display("FAIL cold_counts got %0d/%0d want 1/1", branch_count_o, mispredict_count_o); end
        fetch_pc_i = 32'h100; #1;
        n_chk++; if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h80) begin n_fail++; $display("FAIL cold_predict got %0b/%h want 1/00000080", pred_taken_o, pred_target_o); end
        @(posedge clk); #1;
        n_chk++; if (mispredict_o !== 1'b0 || redirect_pc_o !== 32'h80) begin n_fail++; $display("FAIL cold_hold got %0b/%h want 0/00000080", mispredict_o, redirect_pc_o); end
    endtask

    task automatic test_saturation();
        do_reset();
        fetch_pc_i = 32'h100;
        do_resolve(32'h100, 1, 32'h80, 0, 32'h104);           // allocate weak-T
        for (int k = 0; k < 4; k++) begin
            do_resolve(32'h100, 1, 32'h80, 1, 32'h80);        // climbs to strong-T and stays
            n_chk++; if (mispredict_o !== 1'b0) begin n_fail++; $display("FAIL sat_taken_%0d got mp %0b want 0", k, mispredict_o); end
        end
        do_resolve(32'h100, 0, 32'h80, 1, 32'h80);            // strong-T -> weak-T
        n_chk++; if (mispredict_o !== 1'b1 || redirect_pc_o !== 32'h104) begin n_fail++; $display("FAIL sat_nt1_redirect got %0b/%h want 1/00000104", mispredict_o, redirect_pc_o); end
        n_chk++; if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h80) begin n_fail++; $display("FAIL sat_nt1_predict got %0b/%h want 1/00000080", pred_taken_o, pred_target_o); end
        do_resolve(32'h100, 0, 32'h80, 1, 32'h80);            // weak-T -> weak-NT
        n_chk++; if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h104) begin n_fail++; $display("FAIL sat_nt2_predict got %0b/%h want 0/00000104", pred_taken_o, pred_target_o); end
        n_chk++; if (branch_count_o !== 7 || mispredict_count_o !== 3) begin n_fail++; $display("FAIL sat_counts got %0d/%0d want 7/3", branch_count_o, mispredict_count_o); end
    endtask

    task automatic test_alias();
        do_reset();
        do_resolve(32'h100, 1, 32'h80, 0, 32'h104);
        do_resolve(32'h140, 1, 32'h200, 0, 32'h144);
        fetch_pc_i = 32'h100; #1;
        n_chk++; if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h104) begin n_fail++; $display("FAIL alias_old got %0b/%h want 0/00000104", pred_taken_o, pred_target_o); end
        fetch_pc_i = 32'h140; #1;
        n_chk++; if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h200) begin n_fail++; $display("FAIL alias_new got %0b/%h want 1/00000200", pred_taken_o, pred_target_o); end
        do_resolve(32'h100, 0, 32'h0, 0, 32'h0);             // not-taken alias must not evict
        n_chk++; if (mispredict_o !== 1'b0 || pred_taken_o !== 1'b1 || pred_target_o !== 32'h200) begin n_fail++; $display("FAIL alias_nt got %0b/%0b/%h want 0/1/00000200", mispredict_o, pred_taken_o, pred_target_o); end
    endtask

    task automatic test_target_change();
        do_reset();
        do_resolve(32'h100, 1, 32'h80, 0, 32'h104);
        do_resolve(32'h100, 1, 32'h80, 1, 32'h80);
        do_resolve(32'h100, 1, 32'hC0, 1, 32'h80);
        n_chk++; if (mispredict_o !== 1'b1 || redirect_pc_o !== 32'hC0) begin n_fail++; $display("FAIL tgt_redirect got %0b/%h want 1/000000c0", mispredict_o, redirect_pc_o); end
        fetch_pc_i = 32'h100; #1;
        n_chk++; if (pred_taken_o !== 1'b1 || pred_target_o !== 32'hC0) begin n_fail++; $display("FAIL tgt_predict got %0b/%h want 1/000000c0", pred_taken_o, pred_target_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        do_resolve(32'h200, 1, 32'h300, 0, 32'h204);
        n_chk++; if (mispredict_o !== 1'b1 || redirect_pc_o !== 32'h300) begin n_fail++; $display("FAIL b2b_first got %0b/%h want 1/00000300", mispredict_o, redirect_pc_o); end
        do_resolve(32'h204, 0, 32'h0, 1, 32'h400);
        n_chk++; if (mispredict_o !== 1'b1 || redirect_pc_o !== 32'h208) begin n_fail++; $display("FAIL b2b_second got %0b/%h want 1/00000208", mispredict_o, redirect_pc_o); end
        @(posedge clk); #1;
        n_chk++; if (mispredict_o !== 1'b0 || redirect_pc_o !== 32'h208) begin n_fail++; $display("FAIL b2b_hold got %0b/%h want 0/00000208", mispredict_o, redirect_pc_o); end
        n_chk++; if (branch_count_o !== 2 || mispredict_count_o !== 2) begin n_fail++; $display("FAIL b2b_counts got %0d/%0d want 2/2", branch_count_o, mispredict_count_o); end
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        do_resolve(32'h100, 1, 32'h80, 0, 32'h104);
        do_resolve(32'h3C, 1, 32'h10, 0, 32'h40);
        reset = 1'b1;
        resolve_valid_i = 1'b1; resolve_pc_i = 32'h100; resolve_taken_i = 1'b1;
        resolve_target_i = 32'h900; resolve_pred_taken_i = 1'b0; resolve_pred_target_i = 32'h104;
        @(posedge clk); #1;
        reset = 1'b0; resolve_valid_i = 1'b0;
        model_reset();
        n_chk++; if (mispredict_o !== 1'b0 || branch_count_o !== 0 || mispredict_count_o !== 0) begin n_fail++; $display("FAIL rstmid_state got %0b/%0d/%0d want 0/0/0", mispredict_o, branch_count_o, mispredict_count_o); end
        foreach (m_tgt[i]) begin
            logic [31:0] pc = 32'h100 + 32'(i) * 4;
            fetch_pc_i = pc; #1;
            n_chk++; if (pred_taken_o !== 1'b0 || pred_target_o !== pc + 32'd4) begin n_fail++; $display("FAIL rstmid_pred_%0d got %0b/%h want 0/%h", i, pred_taken_o, pred_target_o, pc + 32'd4); end
        end
        fetch_pc_i = 32'h3C; #1;
        n_chk++; if (pred_taken_o !== 1'b0 || pred_target_o !== 32'h40) begin n_fail++; $display("FAIL rstmid_pred_3c got %0b/%h want 0/00000040", pred_taken_o, pred_target_o); end
        fetch_pc_i = 32'hFFFF_FFFC; #1;
        n_chk++; if (pred_target_o !== 32'h0) begin n_fail++; $display("FAIL wrap_target got %h want 00000000", pred_target_o); end
    endtask

    task automatic test_random();
        logic [31:0] tgts [4] = '{32'h80, 32'hC0, 32'h200, 32'hFFFF_FFF0};
        do_reset();
        for (int n = 0; n < 300; n++) begin
            logic [31:0] fpc, rpc, tgt, ptg, exp_tgt;
            bit t, pt, exp_t, rv;
            fpc = ($urandom_range(1) << 6) | ($urandom_range(3) << 2) | $urandom_range(3);
            rpc = ($urandom_range(1) << 6) | ($urandom_range(3) << 2) | $urandom_range(3);
            t   = $urandom_range(1);
            tgt = tgts[$urandom_range(3)];
            rv  = ($urandom_range(9) < 7);
            if ($urandom_range(1)) model_predict(rpc, pt, ptg);
            else begin pt = $urandom_range(1); ptg = tgts[$urandom_range(3)]; end
            fetch_pc_i = fpc;
            resolve_valid_i = rv; resolve_pc_i = rpc; resolve_taken_i = t;
            resolve_target_i = tgt; resolve_pred_taken_i = pt; resolve_pred_target_i = ptg;
            #1;
            model_predict(fpc, exp_t, exp_tgt);                // pre-update view, no bypass
            n_chk++; if (pred_taken_o !== exp_t || pred_target_o !== exp_tgt) begin n_fail++; $display("FAIL rnd_pred_%0d pc %h got %0b/%h want %0b/%h", n, fpc, pred_taken_o, pred_target_o, exp_t, exp_tgt); end
            @(posedge clk);
            if (rv) model_resolve(rpc, t, tgt, pt, ptg);
            else m_mp = 0;
            #1;
            resolve_valid_i = 1'b0;
            n_chk++; if (mispredict_o !== m_mp || redirect_pc_o !== m_redir) begin n_fail++; $display("FAIL rnd_redirect_%0d got %0b/%h want %0b/%h", n, mispredict_o, redirect_pc_o, m_mp, m_redir); end
            n_chk++; if (branch_count_o !== m_bcnt || mispredict_count_o !== m_mcnt) begin n_fail++; $display("FAIL rnd_counts_%0d got %0d/%0d want %0d/%0d", n, branch_count_o, mispredict_count_o, m_bcnt, m_mcnt); end
        end
    endtask

    initial begin
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_cold_taken();
        test_saturation();
        test_alias();
        test_target_change();
        test_back_to_back();
        test_reset_mid_stream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
